// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - shared constants and hex glyph table for the 7-segment driver
package hex_disp_pkg;

    localparam int SEG_W = 7;

    // All segments off on an active-low display.
    localparam logic [SEG_W-1:0] SEG_BLANK_AL = 7'h7F;

    // Active-low glyph for one nibble, bit order {g,f,e,d,c,b,a}.
    function automatic logic [SEG_W-1:0] hex_glyph(input logic [3:0] nibble);
        logic [SEG_W-1:0] g;
        case (nibble)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
            default: g = SEG_BLANK_AL;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// rtl/hex7seg_decode.sv - combinational nibble to 7-segment decoder
module hex7seg_decode
    import hex_disp_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    // Table is stored active-low; invert it for active-high boards.
    always_comb begin
        seg_o = hex_glyph(nibble_i);
        if (!ACTIVE_LOW) begin
            seg_o = ~hex_glyph(nibble_i);
        end
    end

endmodule

// File: rtl/hex_display_driver.sv
// rtl/hex_display_driver.sv - registered multi-digit hex display driver with blink, LZ blank and PWM dimming
module hex_display_driver
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter int PWM_W      = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic [4*NUM_DIGITS-1:0]     data_in,
    input  logic [NUM_DIGITS-1:0]       blink_mask,
    input  logic                        lz_en,
    input  logic [PWM_W-1:0]            brightness,
    output logic [SEG_W*NUM_DIGITS-1:0] segs,
    output logic                        blink_phase
);

    localparam int                BC_W       = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BC_W-1:0]   BLINK_LAST = BC_W'(BLINK_DIV - 1);
    localparam logic [SEG_W-1:0]  BLANK      = ACTIVE_LOW ? SEG_BLANK_AL : ~SEG_BLANK_AL;

    logic [4*NUM_DIGITS-1:0]     data_q;
    logic [NUM_DIGITS-1:0]       blink_q;
    logic                        lz_q;
    logic [BC_W-1:0]             blink_cnt_q, blink_cnt_d;
    logic                        blink_phase_q, blink_phase_d;
    logic [PWM_W-1:0]            pwm_cnt_q, pwm_cnt_d;
    logic                        pwm_lit;
    logic [NUM_DIGITS-1:0]       lz_blank;
    logic [NUM_DIGITS-1:0]       blink_blank;
    logic [NUM_DIGITS:0]         zero_above;
    logic [SEG_W*NUM_DIGITS-1:0] glyphs;
    logic [SEG_W*NUM_DIGITS-1:0] segs_q, segs_d;

    // Capture the display word and its attributes whenever load is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            blink_q <= '0;
            lz_q    <= 1'b0;
        end else if (load) begin
            data_q  <= data_in;
            blink_q <= blink_mask;
            lz_q    <= lz_en;
        end
    end

    // Free-running blink divider; phase flips each time the divider wraps.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // PWM ramp simply wraps through its full range.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
    end

    // Blink and PWM counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pwm_cnt_q     <= '0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pwm_cnt_q     <= pwm_cnt_d;
        end
    end

    // Full-scale brightness is forced on so the top code never flickers.
    always_comb begin
        pwm_lit = 1'b0;
        if (&brightness) begin
            pwm_lit = 1'b1;
        end else if (pwm_cnt_q < brightness) begin
            pwm_lit = 1'b1;
        end
    end

    assign zero_above[NUM_DIGITS] = 1'b1;
    assign blink_blank            = blink_q & {NUM_DIGITS{blink_phase_q}};

    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
            // Chain of "this digit and every digit above it is zero".
            assign zero_above[k] = zero_above[k+1] & (data_q[4*k +: 4] == 4'h0);

            if (k == 0) begin : g_lsd
                // The least significant digit always shows, so zero reads as "0".
                assign lz_blank[k] = 1'b0;
            end else begin : g_upper
                assign lz_blank[k] = lz_q & zero_above[k];
            end

            hex7seg_decode #(
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_decode (
                .nibble_i (data_q[4*k +: 4]),
                .seg_o    (glyphs[SEG_W*k +: SEG_W])
            );

            assign segs_d[SEG_W*k +: SEG_W] =
                (lz_blank[k] | blink_blank[k] | ~pwm_lit) ? BLANK : glyphs[SEG_W*k +: SEG_W];
        end
    endgenerate

    // Single output register so the pins never see a combinational path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segs_q <= {NUM_DIGITS{BLANK}};
        end else begin
            segs_q <= segs_d;
        end
    end

    assign segs        = segs_q;
    assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// tb/tb_hex_display_driver.sv - scoreboard bench for hex_display_driver
module tb_hex_display_driver;

    localparam int ND = 6;
    localparam int BD = 4;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [23:0]   data_in;
    logic [5:0]    blink_mask;
    logic          lz_en;
    logic [1:0]    brightness;
    logic [41:0]   segs;
    logic          blink_phase;

    always #5 clk = ~clk;

    hex_display_driver #(
        .NUM_DIGITS (ND),
        .BLINK_DIV  (BD),
        .PWM_W      (PW),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .data_in     (data_in),
        .blink_mask  (blink_mask),
        .lz_en       (lz_en),
        .brightness  (brightness),
        .segs        (segs),
        .blink_phase (blink_phase)
    );

    typedef struct {
        int          cyc;
        logic [41:0] segs;
        logic        ph;
        bit          chk_ph;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          rel0  = 0;
    logic [23:0] m_data;
    logic [5:0]  m_mask;
    logic        m_lz;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] gl(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Expected pins after edge e (edges counted from reset release).
    function automatic logic [41:0] model_segs(input logic [23:0] d, input logic [5:0] m,
                                               input logic lz, input logic [1:0] b, input int e);
        logic [41:0] r;
        int          hi;
        int          pw;
        logic        ph_before;
        logic        lit;
        logic        blank;
        hi = -1;
        for (int k = 0; k < ND; k++) begin
            if (d[4*k +: 4] != 4'h0) hi = k;
        end
        ph_before = (((e - 1) / BD) % 2) == 1;
        pw        = (e - 1) % 4;
        lit       = (b == 2'd3) ? 1'b1 : (pw < int'(b));
        for (int k = 0; k < ND; k++) begin
            blank = (lz && k > hi && k != 0) || (m[k] && ph_before) || !lit;
            r[7*k +: 7] = blank ? 7'h7F : gl(d[4*k +: 4]);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cyc=%0d: got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    // Drive one cycle of inputs and predict the pins after the coming edge.
    task automatic tick(input logic ld, input logic [23:0] d, input logic [5:0] m,
                        input logic lz, input logic [1:0] b);
        exp_t it;
        int   e;
        load       = ld;
        data_in    = d;
        blink_mask = m;
        lz_en      = lz;
        brightness = b;
        e          = cyc + 1 - rel0;
        it.cyc     = cyc + 1;
        it.segs    = model_segs(m_data, m_mask, m_lz, b, e);
        it.ph      = ((e / BD) % 2) == 1;
        it.chk_ph  = 1'b1;
        sb.push_back(it);
        if (ld) begin
            m_data = d;
            m_mask = m;
            m_lz   = lz;
        end
        @(negedge clk);
    endtask

    // Hand-computed pin value expected off cycles from now.
    task automatic lit(input int off, input logic [41:0] v);
        exp_t it;
        it.cyc    = cyc + off;
        it.segs   = v;
        it.ph     = 1'b0;
        it.chk_ph = 1'b0;
        sb.push_back(it);
    endtask

    task automatic do_reset();
        load = 1'b0;
        #3 reset = 1'b1;
        #1;
        chk("rst_segs", 64'(segs), 64'h3FF_FFFF_FFFF);
        chk("rst_phase", 64'(blink_phase), 64'h0);
        @(negedge clk);
        chk("rst_held", 64'(segs), 64'h3FF_FFFF_FFFF);
        @(negedge clk);
        reset  = 1'b0;
        rel0   = cyc;
        m_data = '0;
        m_mask = '0;
        m_lz   = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t it;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            if (it.cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL sb_stale: item for cyc=%0d seen at cyc=%0d", it.cyc, cyc);
            end else begin
                chk("segs", 64'(segs), 64'(it.segs));
                if (it.chk_ph) chk("blink_phase", 64'(blink_phase), 64'(it.ph));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        data_in    = '0;
        blink_mask = '0;
        lz_en      = 1'b0;
        brightness = '0;
        m_data     = '0;
        m_mask     = '0;
        m_lz       = 1'b0;
        @(negedge clk);
        do_reset();

        repeat (2) tick(1'b0, 24'h0, 6'h0, 1'b0, 2'd3);

        tick(1'b1, 24'h12AB3F, 6'h0, 1'b0, 2'd3);
        lit(1, {7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E});
        repeat (3) tick(1'b0, 24'h0, 6'h0, 1'b0, 2'd3);

        tick(1'b1, 24'h000050, 6'h0, 1'b1, 2'd3);
        lit(1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40});
        repeat (2) tick(1'b0, 24'h0, 6'h0, 1'b0, 2'd3);

        tick(1'b1, 24'h000000, 6'h0, 1'b1, 2'd3);
        lit(1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        repeat (2) tick(1'b0, 24'h0, 6'h0, 1'b0, 2'd3);

        tick(1'b1, 24'h98C7D6, 6'h0, 1'b0, 2'd0);
        repeat (8) tick(1'b0, 24'h0, 6'h0, 1'b0, 2'd0);
        repeat (8) tick(1'b0, 24'h0, 6'h0, 1'b0, 2'd1);
        repeat (4) tick(1'b0, 24'h0, 6'h0, 1'b0, 2'd2);
        repeat (4) tick(1'b0, 24'h0, 6'h0, 1'b0, 2'd3);

        tick(1'b1, 24'h12AB3F, 6'b000001, 1'b0, 2'd3);
        for (int i = 0; i < 24; i++) begin
            if (i > 8 && i < 14 && ((cyc + 1 - rel0) % BD) == 0)
                tick(1'b1, 24'h654321, 6'b000001, 1'b0, 2'd3);
            else
                tick(1'b0, 24'h0, 6'h0, 1'b0, 2'd3);
        end

        do_reset();

        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 24'(24'h111111 * i) ^ 24'h0F00F0, 6'h0, (i % 2) == 1, 2'd3);
        end
        repeat (3) tick(1'b0, 24'h0, 6'h0, 1'b0, 2'd3);

        tick(1'b1, 24'h000F00, 6'b101010, 1'b1, 2'd2);
        repeat (16) tick(1'b0, 24'h0, 6'h0, 1'b0, 2'd2);
        repeat (3) tick(1'b0, 24'h0, 6'h0, 1'b0, 2'd3);

        @(negedge clk);
        chk("sb_drain", 64'(sb.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
